// File: rtl/pipe_stage_elastic.sv
// Elastic two-entry pipeline stage (main + skid register).
// Decouples upstream and downstream handshakes: in_ready depends only on
// registered state, so no combinational path runs from out_ready to in_ready.
// Output payload always comes from the main register. A saturating counter
// records cycles in which held data was blocked by the downstream stage.
module pipe_stage_elastic #(
    parameter int DATA_W              = 40,
    parameter int CTRL_W              = 9,
    parameter bit ZERO_CTRL_ON_BUBBLE = 1'b1,
    parameter int CNT_W               = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Number of held entries; the encoding is the entry count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;

    logic [DATA_W-1:0]  main_data_q;
    logic [CTRL_W-1:0]  main_ctrl_q;
    logic [DATA_W-1:0]  skid_data_q;
    logic [CTRL_W-1:0]  skid_ctrl_q;
    logic [CNT_W-1:0]   stall_cnt_q;

    logic               in_fire;
    logic               out_fire;
    logic               load_main_in;
    logic               load_main_skid;
    logic               load_skid;
    logic               stalled;

    // Handshake flags come from registered state only.
    assign out_valid = (state_q != EMPTY);
    assign in_ready  = (state_q != TWO);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign stalled   = out_valid & ~out_ready;

    // Next-state and register-load decode; flush overrides every transition.
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        load_main_in = 1'b1;
                        state_d      = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        load_main_in = 1'b1;
                    end else if (in_fire) begin
                        load_skid = 1'b1;
                        state_d   = TWO;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        load_main_skid = 1'b1;
                        state_d        = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Main register: filled from the input or promoted from the skid entry.
    // NOTE: the payload registers are reset so outputs read zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_data_q <= '0;
            main_ctrl_q <= '0;
        end else if (load_main_in) begin
            main_data_q <= in_data;
            main_ctrl_q <= in_ctrl;
        end else if (load_main_skid) begin
            main_data_q <= skid_data_q;
            main_ctrl_q <= skid_ctrl_q;
        end
    end

    // Skid register: catches the entry accepted while main is blocked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else if (load_skid) begin
            skid_data_q <= in_data;
            skid_ctrl_q <= in_ctrl;
        end
    end

    // Saturating stall counter; survives flush, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (stalled && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    // Output decode: control is optionally masked during bubbles.
    always_comb begin
        out_data = main_data_q;
        out_ctrl = main_ctrl_q;
        if (ZERO_CTRL_ON_BUBBLE && (state_q == EMPTY)) begin
            out_ctrl = '0;
        end
    end

    // Occupancy mirrors the entry count held by the state.
    always_comb begin
        occupancy = 2'd0;
        unique case (state_q)
            ONE:     occupancy = 2'd1;
            TWO:     occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench for pipe_stage_elastic: directed scenarios plus random
// traffic, compared each cycle against a queue-based model of the stage.
module tb_pipe_stage_elastic;

    localparam int DATA_W = 8;
    localparam int CTRL_W = 9;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        occupancy;
    logic [15:0]       stall_cnt;

    // Second instance with a narrow counter for the saturation case.
    logic              in_valid2;
    logic              in_ready2;
    logic              out_valid2;
    logic              out_ready2;
    logic [DATA_W-1:0] out_data2;
    logic [CTRL_W-1:0] out_ctrl2;
    logic [1:0]        occupancy2;
    logic [3:0]        stall_cnt2;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: FIFO of {ctrl,data} entries, capacity two.
    logic [CTRL_W+DATA_W-1:0] q[$];
    int unsigned              m_stall;

    pipe_stage_elastic #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .ZERO_CTRL_ON_BUBBLE(1'b1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    pipe_stage_elastic #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .ZERO_CTRL_ON_BUBBLE(1'b1), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(8'h77), .in_ctrl(9'h1FF),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .out_ctrl(out_ctrl2),
        .occupancy(occupancy2), .stall_cnt(stall_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit fi;
        bit fo;
        fi = in_valid && (q.size() < 2);
        fo = (q.size() > 0) && out_ready;
        if ((q.size() > 0) && !out_ready && (m_stall < 32'hFFFF)) m_stall++;
        if (flush) begin
            q.delete();
        end else begin
            if (fo) void'(q.pop_front());
            if (fi) q.push_back({in_ctrl, in_data});
        end
    endtask

    task automatic compare_dut();
        logic [CTRL_W+DATA_W-1:0] head;
        check("out_valid", 32'(out_valid), 32'(q.size() > 0));
        check("in_ready", 32'(in_ready), 32'(q.size() < 2));
        check("occupancy", 32'(occupancy), 32'(q.size()));
        check("stall_cnt", 32'(stall_cnt), m_stall);
        if (q.size() > 0) begin
            head = q[0];
            check("out_data", 32'(out_data), 32'(head[DATA_W-1:0]));
            check("out_ctrl", 32'(out_ctrl), 32'(head[CTRL_W+DATA_W-1:DATA_W]));
        end else begin
            check("out_ctrl_bubble", 32'(out_ctrl), 32'h0);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_dut();
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic rdy);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = CTRL_W'({1'b1, d});
        out_ready = rdy;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0;
        in_valid2 = 1'b0; out_ready2 = 1'b0;
        m_stall = 0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_out_ctrl", 32'(out_ctrl), 32'h0);
        check("rst_occupancy", 32'(occupancy), 32'h0);
        check("rst_stall_cnt", 32'(stall_cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        compare_dut();

        // Streaming at full rate.
        drive(1'b1, 8'h11, 1'b1); cycle();
        check("stream_0", 32'(out_data), 32'h11);
        drive(1'b1, 8'h22, 1'b1); cycle();
        check("stream_1", 32'(out_data), 32'h22);
        check("stream_occ", 32'(occupancy), 32'h1);
        drive(1'b1, 8'h33, 1'b1); cycle();
        check("stream_2", 32'(out_data), 32'h33);
        check("stream_stall", 32'(stall_cnt), 32'h0);
        drive(1'b0, 8'h00, 1'b1); cycle();

        // Backpressure then drain.
        drive(1'b1, 8'hA1, 1'b0); cycle();
        drive(1'b1, 8'hA2, 1'b0); cycle();
        check("bp_occ", 32'(occupancy), 32'h2);
        check("bp_in_ready", 32'(in_ready), 32'h0);
        drive(1'b1, 8'hEE, 1'b0); cycle();
        check("bp_hold", 32'(out_data), 32'hA1);
        check("bp_stall", 32'(stall_cnt), 32'h2);
        drive(1'b0, 8'h00, 1'b1); cycle();
        check("drain_0", 32'(out_data), 32'hA2);
        cycle();
        check("drain_empty", 32'(out_valid), 32'h0);

        // Flush while full with a same-cycle input offer.
        drive(1'b1, 8'hB1, 1'b0); cycle();
        drive(1'b1, 8'hB2, 1'b0); cycle();
        flush = 1'b1; drive(1'b1, 8'h5C, 1'b0); cycle();
        flush = 1'b0;
        check("flush_valid", 32'(out_valid), 32'h0);
        check("flush_ctrl", 32'(out_ctrl), 32'h0);
        check("flush_stall_kept", 32'(stall_cnt), 32'h4);
        drive(1'b0, 8'h00, 1'b1); cycle();
        check("flush_no_5c", 32'(out_valid), 32'h0);

        // Simultaneous in/out fire in ONE.
        drive(1'b1, 8'h01, 1'b0); cycle();
        drive(1'b1, 8'h02, 1'b1); cycle();
        check("simul_data", 32'(out_data), 32'h02);
        check("simul_occ", 32'(occupancy), 32'h1);
        drive(1'b0, 8'h00, 1'b1); cycle();

        // Counter saturation on the narrow instance.
        in_valid2 = 1'b1; cycle();
        in_valid2 = 1'b0;
        repeat (5) cycle();
        check("sat_mid", 32'(stall_cnt2), 32'h5);
        repeat (15) cycle();
        check("sat_stick", 32'(stall_cnt2), 32'hF);
        check("sat_data", 32'(out_data2), 32'h77);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            flush = ($urandom_range(0, 15) == 0);
            drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0);
            in_ctrl = 9'($urandom);
            cycle();
        end
        flush = 1'b0;

        // Async reset pulse while full, away from any clock edge.
        drive(1'b1, 8'h33, 1'b0); cycle();
        drive(1'b1, 8'h44, 1'b0); cycle();
        if (q.size() != 2) begin
            drive(1'b1, 8'h45, 1'b0); cycle();
        end
        check("pre_rst_occ", 32'(occupancy), 32'h2);
        drive(1'b0, 8'h00, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        q.delete(); m_stall = 0;
        check("arst_valid", 32'(out_valid), 32'h0);
        check("arst_occ", 32'(occupancy), 32'h0);
        check("arst_data", 32'(out_data), 32'h0);
        check("arst_ctrl", 32'(out_ctrl), 32'h0);
        check("arst_stall", 32'(stall_cnt), 32'h0);
        check("arst_in_ready", 32'(in_ready), 32'h1);
        #1 rst_n = 1'b1;
        drive(1'b1, 8'h66, 1'b1); cycle();
        check("post_rst_data", 32'(out_data), 32'h66);
        check("post_rst_valid", 32'(out_valid), 32'h1);
        drive(1'b0, 8'h00, 1'b1); cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
